// File: rtl/universal_shift_register.sv
// Parametrised universal shift register: hold, shift left/right, parallel load, and a frame counter.
// Optional rotate modes (100 ROL, 101 ROR) are enabled by defining USR_ROTATE_EN.
module universal_shift_register #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               CW        = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             sin_lsb,
    input  logic             sin_msb,
    input  logic [WIDTH-1:0] par_in,
    output logic [WIDTH-1:0] data_out,
    output logic [CW-1:0]    shift_cnt,
    output logic             frame_done
);

    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_SHL  = 3'b001;
    localparam logic [2:0] MODE_SHR  = 3'b010;
    localparam logic [2:0] MODE_LOAD = 3'b011;
`ifdef USR_ROTATE_EN
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_ROR  = 3'b101;
`endif

    logic [WIDTH-1:0] next_data;
    logic             is_shift;
    logic             is_load;

    // Next-state selection; reserved and unsupported modes fall through to hold.
    always_comb begin
        next_data = data_out;
        is_shift  = 1'b0;
        is_load   = 1'b0;
        case (mode)
            MODE_HOLD: next_data = data_out;
            MODE_SHL: begin
                next_data = {data_out[WIDTH-2:0], sin_lsb};
                is_shift  = 1'b1;
            end
            MODE_SHR: begin
                next_data = {sin_msb, data_out[WIDTH-1:1]};
                is_shift  = 1'b1;
            end
            MODE_LOAD: begin
                next_data = par_in;
                is_load   = 1'b1;
            end
`ifdef USR_ROTATE_EN
            MODE_ROL: begin
                next_data = {data_out[WIDTH-2:0], data_out[WIDTH-1]};
                is_shift  = 1'b1;
            end
            MODE_ROR: begin
                next_data = {data_out[0], data_out[WIDTH-1:1]};
                is_shift  = 1'b1;
            end
`endif
            default: next_data = data_out;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_out   <= RESET_VAL;
            shift_cnt  <= '0;
            frame_done <= 1'b0;
        end else if (en) begin
            data_out   <= next_data;
            frame_done <= 1'b0;
            if (is_load) begin
                shift_cnt <= '0;
            end else if (is_shift) begin
                // The WIDTH-th shift closes the frame and restarts the count.
                if (shift_cnt == LAST_CNT) begin
                    shift_cnt  <= '0;
                    frame_done <= 1'b1;
                end else begin
                    shift_cnt <= shift_cnt + CW'(1);
                end
            end
        end else begin
            frame_done <= 1'b0;
        end
    end

endmodule

// File: tb/tb_universal_shift_register.sv
// Randomised self-checking bench for universal_shift_register (WIDTH=8), with a behavioural reference model.
// Rotate expectations follow USR_ROTATE_EN.
module tb_universal_shift_register;

    logic       clk;
    logic       reset;
    logic       en;
    logic [2:0] mode;
    logic       sin_lsb;
    logic       sin_msb;
    logic [7:0] par_in;
    logic [7:0] data_out;
    logic [2:0] shift_cnt;
    logic       frame_done;

    int checks;
    int errors;

    // Reference model state: integer register value, shifts so far in the frame, pulse flag.
    int m_data;
    int m_cnt;
    int m_done;

    universal_shift_register #(.WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .mode      (mode),
        .sin_lsb   (sin_lsb),
        .sin_msb   (sin_msb),
        .par_in    (par_in),
        .data_out  (data_out),
        .shift_cnt (shift_cnt),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_data = 0;
        m_cnt  = 0;
        m_done = 0;
    endtask

    // Apply one cycle of inputs, advance the model, and return #1 after the rising edge.
    task automatic cycle(input logic e, input logic [2:0] m, input logic sl, input logic sr,
                         input logic [7:0] p);
        int nd;
        int nc;
        int ndone;
        bit shift;
        en = e; mode = m; sin_lsb = sl; sin_msb = sr; par_in = p;
        nd = m_data; nc = m_cnt; ndone = 0; shift = 0;
        if (e) begin
            case (m)
                3'd1: begin nd = (m_data * 2) % 256 + int'(sl); shift = 1; end
                3'd2: begin nd = m_data / 2 + int'(sr) * 128; shift = 1; end
                3'd3: begin nd = int'(p); nc = 0; end
`ifdef USR_ROTATE_EN
                3'd4: begin nd = (m_data * 2) % 256 + m_data / 128; shift = 1; end
                3'd5: begin nd = m_data / 2 + (m_data % 2) * 128; shift = 1; end
`endif
                default: ;
            endcase
            if (shift) begin
                nc = m_cnt + 1;
                if (nc == 8) begin
                    nc = 0;
                    ndone = 1;
                end
            end
        end
        @(posedge clk);
        #1;
        m_data = nd; m_cnt = nc; m_done = ndone;
    endtask

    task automatic test_reset();
        cycle(1'b1, 3'd3, 1'b0, 1'b0, 8'hFF);
        cycle(1'b1, 3'd1, 1'b1, 1'b0, 8'h00);
        reset = 1'b0;
        model_reset();
        #1;
        checks++;
        if (data_out !== 8'h00 || shift_cnt !== 3'd0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_immediate got data=%h cnt=%0d done=%b want 00 0 0",
                     data_out, shift_cnt, frame_done);
        end
        en = 1'b1; mode = 3'd3; par_in = 8'h5A;
        @(posedge clk);
        #1;
        checks++;
        if (data_out !== 8'h00 || shift_cnt !== 3'd0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold got data=%h cnt=%0d done=%b want 00 0 0",
                     data_out, shift_cnt, frame_done);
        end
        reset = 1'b1;
    endtask

    task automatic test_load_shl();
        logic [7:0] exp_d [3];
        exp_d[0] = 8'h4B; exp_d[1] = 8'h97; exp_d[2] = 8'h2F;
        cycle(1'b1, 3'd3, 1'b0, 1'b0, 8'hA5);
        checks++;
        if (data_out !== 8'hA5 || shift_cnt !== 3'd0) begin
            errors++;
            $display("FAIL load got data=%h cnt=%0d want a5 0", data_out, shift_cnt);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 3'd1, 1'b1, 1'b0, 8'h00);
            checks++;
            if (data_out !== exp_d[i] || shift_cnt !== 3'(i + 1) || frame_done !== 1'b0) begin
                errors++;
                $display("FAIL shl_%0d got data=%h cnt=%0d done=%b want %h %0d 0",
                         i, data_out, shift_cnt, frame_done, exp_d[i], i + 1);
            end
        end
    endtask

    task automatic test_full_frame_shr();
        logic [7:0] bits;
        bits = 8'b1100_1101; // bit i is the serial input on shift i
        cycle(1'b1, 3'd3, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 3'd2, 1'b0, bits[i], 8'h00);
            if (i < 7) begin
                checks++;
                if (frame_done !== 1'b0 || shift_cnt !== 3'(i + 1)) begin
                    errors++;
                    $display("FAIL shr_frame_%0d got cnt=%0d done=%b want %0d 0",
                             i, shift_cnt, frame_done, i + 1);
                end
            end
        end
        checks++;
        if (data_out !== 8'hCD || shift_cnt !== 3'd0 || frame_done !== 1'b1) begin
            errors++;
            $display("FAIL shr_wrap got data=%h cnt=%0d done=%b want cd 0 1",
                     data_out, shift_cnt, frame_done);
        end
        cycle(1'b1, 3'd0, 1'b0, 1'b0, 8'h00);
        checks++;
        if (frame_done !== 1'b0 || data_out !== 8'hCD) begin
            errors++;
            $display("FAIL shr_pulse_end got data=%h done=%b want cd 0", data_out, frame_done);
        end
    endtask

    task automatic test_enable();
        cycle(1'b1, 3'd3, 1'b0, 1'b0, 8'h3C);
        cycle(1'b1, 3'd1, 1'b0, 1'b0, 8'h00);
        cycle(1'b1, 3'd1, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 3'd1, 1'b1, 1'b1, 8'hFF);
            checks++;
            if (data_out !== 8'hF1 || shift_cnt !== 3'd2 || frame_done !== 1'b0) begin
                errors++;
                $display("FAIL enable_%0d got data=%h cnt=%0d done=%b want f1 2 0",
                         i, data_out, shift_cnt, frame_done);
            end
        end
        // A wrap edge followed by en=0 must still drop the pulse.
        for (int i = 0; i < 6; i++) cycle(1'b1, 3'd2, 1'b0, 1'b0, 8'h00);
        cycle(1'b0, 3'd2, 1'b0, 1'b0, 8'h00);
        checks++;
        if (frame_done !== 1'b0 || shift_cnt !== 3'd0) begin
            errors++;
            $display("FAIL enable_after_wrap got cnt=%0d done=%b want 0 0", shift_cnt, frame_done);
        end
    endtask

    task automatic test_reset_mid_frame();
        cycle(1'b1, 3'd3, 1'b0, 1'b0, 8'h96);
        for (int i = 0; i < 5; i++) cycle(1'b1, 3'd1, 1'b1, 1'b0, 8'h00);
        reset = 1'b0;
        model_reset();
        #2;
        checks++;
        if (data_out !== 8'h00 || shift_cnt !== 3'd0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got data=%h cnt=%0d done=%b want 00 0 0",
                     data_out, shift_cnt, frame_done);
        end
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, (i % 2 == 0) ? 3'd1 : 3'd2, 1'b1, 1'b0, 8'h00);
            checks++;
            if (frame_done !== ((i == 7) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL mid_reset_frame_%0d got done=%b want %b",
                         i, frame_done, (i == 7) ? 1'b1 : 1'b0);
            end
        end
    endtask

    task automatic test_rotate();
        cycle(1'b1, 3'd3, 1'b0, 1'b0, 8'h81);
`ifdef USR_ROTATE_EN
        cycle(1'b1, 3'd4, 1'b0, 1'b1, 8'h00);
        checks++;
        if (data_out !== 8'h03 || shift_cnt !== 3'd1) begin
            errors++;
            $display("FAIL rol got data=%h cnt=%0d want 03 1", data_out, shift_cnt);
        end
        cycle(1'b1, 3'd5, 1'b1, 1'b0, 8'h00);
        checks++;
        if (data_out !== 8'h81 || shift_cnt !== 3'd2) begin
            errors++;
            $display("FAIL ror1 got data=%h cnt=%0d want 81 2", data_out, shift_cnt);
        end
        cycle(1'b1, 3'd5, 1'b1, 1'b0, 8'h00);
        checks++;
        if (data_out !== 8'hC0 || shift_cnt !== 3'd3) begin
            errors++;
            $display("FAIL ror2 got data=%h cnt=%0d want c0 3", data_out, shift_cnt);
        end
`else
        cycle(1'b1, 3'd4, 1'b1, 1'b1, 8'h00);
        checks++;
        if (data_out !== 8'h81 || shift_cnt !== 3'd0) begin
            errors++;
            $display("FAIL rol_disabled got data=%h cnt=%0d want 81 0", data_out, shift_cnt);
        end
        cycle(1'b1, 3'd5, 1'b1, 1'b1, 8'h00);
        checks++;
        if (data_out !== 8'h81 || shift_cnt !== 3'd0) begin
            errors++;
            $display("FAIL ror_disabled got data=%h cnt=%0d want 81 0", data_out, shift_cnt);
        end
`endif
        for (int m = 6; m < 8; m++) begin
            cycle(1'b1, 3'(m), 1'b1, 1'b1, 8'hFF);
            checks++;
            if (data_out !== 8'(m_data) || shift_cnt !== 3'(m_cnt)) begin
                errors++;
                $display("FAIL reserved_%0d got data=%h cnt=%0d want %h %0d",
                         m, data_out, shift_cnt, 8'(m_data), m_cnt);
            end
        end
    endtask

    task automatic test_random();
        logic       e;
        logic [2:0] m;
        for (int i = 0; i < 400; i++) begin
            e = ($urandom_range(0, 7) != 0);
            m = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 7));
            cycle(e, m, 1'($urandom), 1'($urandom), 8'($urandom));
            checks++;
            if (data_out !== 8'(m_data) || shift_cnt !== 3'(m_cnt) || frame_done !== 1'(m_done)) begin
                errors++;
                $display("FAIL random_%0d got data=%h cnt=%0d done=%b want %h %0d %0d",
                         i, data_out, shift_cnt, frame_done, 8'(m_data), m_cnt, m_done);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b0; en = 1'b0; mode = 3'd0;
        sin_lsb = 1'b0; sin_msb = 1'b0; par_in = 8'h00;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        test_reset();
        test_load_shl();
        test_full_frame_shr();
        test_enable();
        test_reset_mid_frame();
        test_rotate();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/universal_shift_register.md
Name: universal_shift_register

Overview:
Parametrised successor to the team's fixed 8-bit serial-in shift register. Adds generic width, a mode-selected operation set (hold, shift left/right, parallel load), clock enable, and a shift counter. The counter raises a one-cycle frame_done pulse every WIDTH shifts. Used as the common serializer/deserializer building block in lab datapaths.

Parameters:
WIDTH, 8, register width in bits; legal range WIDTH >= 2.
RESET_VAL, 0, value loaded into data_out on reset (WIDTH bits).
CW, $clog2(WIDTH), shift_cnt width; derived, not overridden.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous, active-low reset.
en  input  1  clock enable; 0 = hold everything.
mode  input  3  operation select (see Behaviour).
sin_lsb  input  1  serial bit entering bit 0 on shift left.
sin_msb  input  1  serial bit entering bit WIDTH-1 on shift right.
par_in  input  WIDTH  parallel load data.
data_out  output  WIDTH  register contents (registered).
shift_cnt  output  CW  shifts completed in the current frame, 0..WIDTH-1.
frame_done  output  1  one-cycle pulse after the WIDTH-th shift of a frame.

Behaviour:
- Reset (reset=0): immediate, no clock edge needed. data_out=RESET_VAL, shift_cnt=0, frame_done=0. All outputs hold these values while reset stays low.
- All updates occur on the rising clk edge, with reset=1 and en=1. Latency is one cycle: the new data_out is visible after the edge.
- en=0: data_out and shift_cnt hold. frame_done=0 on that cycle.
- mode 000 HOLD: no change; shift_cnt holds.
- mode 001 SHL: data_out <= {data_out[WIDTH-2:0], sin_lsb}. Counts as a shift.
- mode 010 SHR: data_out <= {sin_msb, data_out[WIDTH-1:1]}. Counts as a shift.
- mode 011 LOAD: data_out <= par_in; shift_cnt <= 0. Any partial frame is discarded.
- modes 100/101: rotate (see Optional Feature), otherwise HOLD.
- modes 110/111: reserved. Act as HOLD; no counter change.
- Counter, on a shift: if shift_cnt == WIDTH-1, then shift_cnt <= 0 and frame_done <= 1 for exactly one cycle. Otherwise shift_cnt increments and frame_done <= 0.
- frame_done is registered and asserted the cycle after the wrapping edge. It is 0 on every cycle that does not follow a wrap.
- Mixing SHL and SHR within a frame is legal. Both directions count toward the same frame.
- Reset mid-frame: partial count is discarded. After release, the next shift is counted as shift 1 of a new frame.
- Reset release is synchronised externally. The block needs no internal synchroniser.

Optional Feature:
Macro: USR_ROTATE_EN.
- Defined: mode 100 ROL, data_out <= {data_out[WIDTH-2:0], data_out[WIDTH-1]}. Mode 101 ROR, data_out <= {data_out[0], data_out[WIDTH-1:1]}. Both count as shifts and feed the frame counter; serial inputs are ignored.
- Not defined: modes 100/101 behave as HOLD. No rotate logic is synthesised.

Test Plan:
1. Reset: drive reset=0 with no clock edge -> data_out=8'h00, shift_cnt=0, frame_done=0 immediately (WIDTH=8).
2. Load then shift left: LOAD par_in=8'hA5, then SHL three times with sin_lsb=1 -> data_out 8'h4B, 8'h97, 8'h2F; shift_cnt 1, 2, 3; frame_done stays 0.
3. Full frame right: after LOAD, apply SHR eight times with sin_msb=1,0,1,1,0,0,1,1 -> data_out=8'hCD. shift_cnt wraps 7->0 on the 8th edge; frame_done=1 for exactly the following cycle only.
4. Enable gating: en=0 with mode=001 for 4 cycles -> data_out and shift_cnt unchanged, frame_done=0.
5. Reset mid-frame: after 5 shifts, pulse reset low between edges -> outputs clear at once. After release, 8 more shifts are needed to produce frame_done.
6. Rotate: LOAD 8'h81, then mode 100 once -> 8'h03, then mode 101 twice -> 8'h81, 8'hC0, with USR_ROTATE_EN defined. Without the macro, mode 100 leaves 8'h81 and shift_cnt=0.
